// File: rtl/dmem_sb_pkg.sv
// rtl/dmem_sb_pkg.sv - shared types and sizing for the data-memory store buffer
// Contents: default geometry, the {addr, data} entry type, and the
// pointer/count width helpers derived from DEPTH.
package dmem_sb_pkg;

   localparam int SB_DEPTH  = 4;
   localparam int SB_ADDR_W = 64;
   localparam int SB_DATA_W = 64;

   // Pointer indexes DEPTH entries; the count needs one more bit to hold DEPTH itself.
   function automatic int sb_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int sb_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int SB_PTR_W = sb_ptr_w(SB_DEPTH);
   localparam int SB_CNT_W = sb_cnt_w(SB_DEPTH);

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/sb_youngest_match.sv
// rtl/sb_youngest_match.sv - picks the youngest matching store for load forwarding
// Ports:
//   match_i      per-entry address match, already qualified by entry validity
//   head_i       index of the oldest entry
//   push_match_i the store being accepted this cycle matches the load
//   hit_o        some store matches
//   push_sel_o   the winner is the same-cycle store (youngest of all)
//   idx_o        buffer index of the winner when push_sel_o is 0
module sb_youngest_match
   import dmem_sb_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH
) (
   input  logic [DEPTH-1:0]         match_i,
   input  logic [$clog2(DEPTH)-1:0] head_i,
   input  logic                     push_match_i,
   output logic                     hit_o,
   output logic                     push_sel_o,
   output logic [$clog2(DEPTH)-1:0] idx_o
);

   localparam int PTR_W = sb_ptr_w(DEPTH);

   // Walk entries in age order starting at head; later hits are younger and
   // overwrite earlier ones. DEPTH is a power of two so the add wraps for free.
   always_comb begin
      logic [PTR_W-1:0] pos;
      pos        = '0;
      hit_o      = push_match_i;
      push_sel_o = push_match_i;
      idx_o      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pos = head_i + PTR_W'(i);
         if (match_i[pos] && !push_match_i) begin
            hit_o = 1'b1;
            idx_o = pos;
         end
      end
   end

endmodule

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - in-order store buffer with load forwarding in front of data memory
// Ports:
//   clk, reset                        clock; asynchronous active-low reset
//   cpu_addressStore_i/writeData_i/   committed store from the core;
//   cpu_writeEn_i/cpu_storeStall_o    stall when the buffer is full
//   cpu_addressLoad_i/cpu_readEn_i/   load from the core; result one cycle later,
//   cpu_readData_o                    forwarded from the buffer when it matches
//   mem_addressLoad_o/mem_readEn_o/   load pass-through to memory
//   mem_readData_i
//   mem_addressStore_o/writeData_o/   head-of-buffer drain to memory
//   mem_writeEn_o/mem_writeReady_i
//   count_o, empty_o                  occupancy
module dmem_store_buffer
   import dmem_sb_pkg::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_W-1:0]          cpu_addressStore_i,
   input  logic [DATA_W-1:0]          cpu_writeData_i,
   input  logic                       cpu_writeEn_i,
   output logic                       cpu_storeStall_o,
   input  logic [ADDR_W-1:0]          cpu_addressLoad_i,
   input  logic                       cpu_readEn_i,
   output logic [DATA_W-1:0]          cpu_readData_o,
   output logic [ADDR_W-1:0]          mem_addressLoad_o,
   output logic                       mem_readEn_o,
   input  logic [DATA_W-1:0]          mem_readData_i,
   output logic [ADDR_W-1:0]          mem_addressStore_o,
   output logic [DATA_W-1:0]          mem_writeData_o,
   output logic                       mem_writeEn_o,
   input  logic                       mem_writeReady_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       empty_o
);

   localparam int PTR_W = sb_ptr_w(DEPTH);
   localparam int CNT_W = sb_cnt_w(DEPTH);

   sb_entry_t        entry_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;

   logic push;
   logic pop;

   // Stall comes from registered occupancy only, so a full buffer refuses a
   // store even when the head drains in the same cycle.
   assign cpu_storeStall_o = (count_q == CNT_W'(DEPTH));
   assign push             = cpu_writeEn_i && !cpu_storeStall_o;
   assign mem_writeEn_o    = (count_q != '0);
   assign pop              = mem_writeEn_o && mem_writeReady_i;

   assign mem_addressStore_o = entry_q[head_q].addr;
   assign mem_writeData_o    = entry_q[head_q].data;
   assign count_o            = count_q;
   assign empty_o            = (count_q == '0);

   assign mem_addressLoad_o = cpu_addressLoad_i;
   assign mem_readEn_o      = cpu_readEn_i;

   // Entry payload needs no reset: validity is tracked separately.
   always_ff @(posedge clk) begin
      if (push) begin
         entry_q[tail_q] <= '{addr: cpu_addressStore_i, data: cpu_writeData_i};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         // Clear before set: head and tail only coincide when full or empty,
         // and then only one of push/pop can fire.
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         if (push) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Forwarding: compare against pre-pop state plus the store accepted now.
   logic [DEPTH-1:0] match;
   logic             push_match;
   logic             fwd_hit;
   logic             fwd_push_sel;
   logic [PTR_W-1:0] fwd_idx;

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = valid_q[i] && (entry_q[i].addr == cpu_addressLoad_i);
      end
   end

   assign push_match = push && (cpu_addressStore_i == cpu_addressLoad_i);

   sb_youngest_match #(.DEPTH(DEPTH)) u_match (
      .match_i      (match),
      .head_i       (head_q),
      .push_match_i (push_match),
      .hit_o        (fwd_hit),
      .push_sel_o   (fwd_push_sel),
      .idx_o        (fwd_idx)
   );

   logic              ld_pend_q;
   logic              hit_q;
   logic [DATA_W-1:0] fwd_q;
   logic [DATA_W-1:0] rd_hold_q;
   logic [DATA_W-1:0] rd_now;

   // Memory data only arrives in the cycle after the request, so the result
   // is muxed combinationally then and held in rd_hold_q afterwards.
   assign rd_now         = hit_q ? fwd_q : mem_readData_i;
   assign cpu_readData_o = ld_pend_q ? rd_now : rd_hold_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_pend_q <= 1'b0;
         hit_q     <= 1'b0;
         fwd_q     <= '0;
         rd_hold_q <= '0;
      end else begin
         ld_pend_q <= cpu_readEn_i;
         if (cpu_readEn_i) begin
            hit_q <= fwd_hit;
            fwd_q <= fwd_push_sel ? cpu_writeData_i : entry_q[fwd_idx].data;
         end
         if (ld_pend_q) begin
            rd_hold_q <= rd_now;
         end
      end
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - directed self-checking bench for dmem_store_buffer
module tb_dmem_store_buffer;
   import dmem_sb_pkg::*;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;

   logic              clk;
   logic              reset;
   logic [ADDR_W-1:0] cpu_addressStore_i;
   logic [DATA_W-1:0] cpu_writeData_i;
   logic              cpu_writeEn_i;
   logic              cpu_storeStall_o;
   logic [ADDR_W-1:0] cpu_addressLoad_i;
   logic              cpu_readEn_i;
   logic [DATA_W-1:0] cpu_readData_o;
   logic [ADDR_W-1:0] mem_addressLoad_o;
   logic              mem_readEn_o;
   logic [DATA_W-1:0] mem_readData_i;
   logic [ADDR_W-1:0] mem_addressStore_o;
   logic [DATA_W-1:0] mem_writeData_o;
   logic              mem_writeEn_o;
   logic              mem_writeReady_i;
   logic [2:0]        count_o;
   logic              empty_o;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk                (clk),
      .reset              (reset),
      .cpu_addressStore_i (cpu_addressStore_i),
      .cpu_writeData_i    (cpu_writeData_i),
      .cpu_writeEn_i      (cpu_writeEn_i),
      .cpu_storeStall_o   (cpu_storeStall_o),
      .cpu_addressLoad_i  (cpu_addressLoad_i),
      .cpu_readEn_i       (cpu_readEn_i),
      .cpu_readData_o     (cpu_readData_o),
      .mem_addressLoad_o  (mem_addressLoad_o),
      .mem_readEn_o       (mem_readEn_o),
      .mem_readData_i     (mem_readData_i),
      .mem_addressStore_o (mem_addressStore_o),
      .mem_writeData_o    (mem_writeData_o),
      .mem_writeEn_o      (mem_writeEn_o),
      .mem_writeReady_i   (mem_writeReady_i),
      .count_o            (count_o),
      .empty_o            (empty_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [63:0] a, input logic [63:0] d);
      cpu_writeEn_i      = 1'b1;
      cpu_addressStore_i = a;
      cpu_writeData_i    = d;
   endtask

   initial begin
      reset              = 1'b0;
      cpu_addressStore_i = '0;
      cpu_writeData_i    = '0;
      cpu_writeEn_i      = 1'b0;
      cpu_addressLoad_i  = '0;
      cpu_readEn_i       = 1'b0;
      mem_readData_i     = '0;
      mem_writeReady_i   = 1'b0;
      tick();
      tick();
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_empty", 64'(empty_o), 64'd1);
      check("rst_wen", 64'(mem_writeEn_o), 64'd0);
      check("rst_stall", 64'(cpu_storeStall_o), 64'd0);
      check("rst_rdata", cpu_readData_o, 64'd0);
      reset = 1'b1;
      tick();

      // Single store drains one cycle after push
      store(64'h100, 64'h11);
      mem_writeReady_i = 1'b1;
      tick();
      cpu_writeEn_i = 1'b0;
      check("s1_wen", 64'(mem_writeEn_o), 64'd1);
      check("s1_addr", mem_addressStore_o, 64'h100);
      check("s1_data", mem_writeData_o, 64'h11);
      check("s1_count", 64'(count_o), 64'd1);
      tick();
      check("s1_count_after", 64'(count_o), 64'd0);
      check("s1_empty_after", 64'(empty_o), 64'd1);
      check("s1_wen_after", 64'(mem_writeEn_o), 64'd0);

      // Fill, full stall, rejected store while head drains
      mem_writeReady_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         store(64'(8 * i), 64'hA0 + 64'(i));
         tick();
      end
      store(64'h20, 64'hE0);
      mem_writeReady_i = 1'b1;
      check("full_count", 64'(count_o), 64'd4);
      check("full_stall", 64'(cpu_storeStall_o), 64'd1);
      tick();
      check("rej_count", 64'(count_o), 64'd3);
      check("rej_stall", 64'(cpu_storeStall_o), 64'd0);
      check("rej_head", mem_addressStore_o, 64'h8);
      mem_writeReady_i = 1'b0;
      tick();
      cpu_writeEn_i = 1'b0;
      check("retry_count", 64'(count_o), 64'd4);
      mem_writeReady_i = 1'b1;
      check("drain0_addr", mem_addressStore_o, 64'h8);
      check("drain0_data", mem_writeData_o, 64'hA1);
      tick();
      check("drain1_addr", mem_addressStore_o, 64'h10);
      tick();
      check("drain2_addr", mem_addressStore_o, 64'h18);
      tick();
      check("drain3_addr", mem_addressStore_o, 64'h20);
      check("drain3_data", mem_writeData_o, 64'hE0);
      tick();
      check("drain_empty", 64'(empty_o), 64'd1);

      // Youngest of two matching entries forwards; memory data ignored
      mem_writeReady_i = 1'b0;
      store(64'h40, 64'hAA);
      tick();
      store(64'h40, 64'hBB);
      tick();
      cpu_writeEn_i     = 1'b0;
      cpu_readEn_i      = 1'b1;
      cpu_addressLoad_i = 64'h40;
      mem_readData_i    = 64'h9999;
      #1;
      check("ld_pass_en", 64'(mem_readEn_o), 64'd1);
      check("ld_pass_addr", mem_addressLoad_o, 64'h40);
      tick();
      cpu_readEn_i = 1'b0;
      check("fwd_young", cpu_readData_o, 64'hBB);
      mem_readData_i = 64'h7777;
      tick();
      check("rdata_hold", cpu_readData_o, 64'hBB);

      // No match passes memory data through
      cpu_readEn_i      = 1'b1;
      cpu_addressLoad_i = 64'h48;
      tick();
      cpu_readEn_i   = 1'b0;
      mem_readData_i = 64'h1234;
      #1;
      check("ld_miss", cpu_readData_o, 64'h1234);

      // Same-cycle store forwards to the load
      store(64'h80, 64'h55);
      cpu_readEn_i      = 1'b1;
      cpu_addressLoad_i = 64'h80;
      tick();
      cpu_writeEn_i  = 1'b0;
      cpu_readEn_i   = 1'b0;
      mem_readData_i = 64'hDEAD;
      #1;
      check("fwd_same_cycle", cpu_readData_o, 64'h55);
      check("same_cycle_count", 64'(count_o), 64'd3);

      // Entry popping in the load cycle still forwards
      mem_writeReady_i = 1'b1;
      tick();
      check("pop_aa_count", 64'(count_o), 64'd2);
      cpu_readEn_i      = 1'b1;
      cpu_addressLoad_i = 64'h40;
      tick();
      cpu_readEn_i = 1'b0;
      check("fwd_popping", cpu_readData_o, 64'hBB);
      check("pop_bb_count", 64'(count_o), 64'd1);
      tick();
      check("pop_all_empty", 64'(empty_o), 64'd1);

      // Pointer wrap: 7 pushes, drain order follows push order
      mem_writeReady_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         store(64'h200 + 64'(8 * i), 64'hC0 + 64'(i));
         tick();
      end
      mem_writeReady_i = 1'b1;
      for (int i = 3; i < 7; i++) begin
         store(64'h200 + 64'(8 * i), 64'hC0 + 64'(i));
         check($sformatf("wrap_addr%0d", i - 3), mem_addressStore_o, 64'h200 + 64'(8 * (i - 3)));
         check($sformatf("wrap_data%0d", i - 3), mem_writeData_o, 64'hC0 + 64'(i - 3));
         tick();
      end
      cpu_writeEn_i = 1'b0;
      check("wrap_count", 64'(count_o), 64'd3);
      check("wrap_addr4", mem_addressStore_o, 64'h220);
      tick();
      check("wrap_addr5", mem_addressStore_o, 64'h228);
      check("wrap_data5", mem_writeData_o, 64'hC5);

      // Asynchronous reset mid-drain
      #2;
      reset = 1'b0;
      #1;
      check("arst_wen", 64'(mem_writeEn_o), 64'd0);
      check("arst_count", 64'(count_o), 64'd0);
      check("arst_empty", 64'(empty_o), 64'd1);
      tick();
      reset = 1'b1;
      tick();

      // Discarded entry no longer forwards after reset
      cpu_readEn_i      = 1'b1;
      cpu_addressLoad_i = 64'h228;
      tick();
      cpu_readEn_i   = 1'b0;
      mem_readData_i = 64'h4242;
      #1;
      check("post_rst_miss", cpu_readData_o, 64'h4242);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
